// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump resolution, iterative 33-cycle divider and the
// EX/MEM pipeline register feeding the memory stage.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_ex,
    input  logic        flush,
    input  logic [4:0]  ctrl_ex,
    input  logic [3:0]  alu_op,
    input  logic        alu_src,
    input  logic        branch_en,
    input  logic [2:0]  funct3,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [31:0] pc_ex,
    input  logic [31:0] pc4_ex,
    input  logic [31:0] rd_ex,
    output logic [4:0]  ctrl_mem,
    output logic [31:0] rd_mem,
    output logic [31:0] pc4_mem,
    output logic [31:0] alu_result,
    output logic [31:0] write_data,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        ex_busy
);

    typedef enum logic [0:0] {StIdle, StRun} div_state_e;

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        dz_q, dz_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        remop_q, remop_d;

    logic [31:0] op_a, op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_out;
    logic        is_div, div_signed, div_rem;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_sh, diff;
    logic        ge;
    logic [31:0] rem_nx, quo_nx, q_fin, r_fin, div_res, result;
    logic        cond, taken;
    logic [31:0] target;

    assign op_a  = rs1_data;
    assign op_b  = alu_src ? imm : rs2_data;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_out = '0;
        unique case (alu_op)
            4'd0:    alu_out = op_a + op_b;
            4'd1:    alu_out = op_a - op_b;
            4'd2:    alu_out = op_a << shamt;
            4'd3:    alu_out = {31'b0, ($signed(op_a) < $signed(op_b))};
            4'd4:    alu_out = {31'b0, (op_a < op_b)};
            4'd5:    alu_out = op_a ^ op_b;
            4'd6:    alu_out = op_a >> shamt;
            4'd7:    alu_out = $unsigned($signed(op_a) >>> shamt);
            4'd8:    alu_out = op_a | op_b;
            4'd9:    alu_out = op_a & op_b;
            4'd10:   alu_out = op_b;
            default: alu_out = '0;
        endcase
    end

    assign is_div     = (alu_op >= 4'd11) && (alu_op <= 4'd14);
    assign div_signed = (alu_op == 4'd11) || (alu_op == 4'd13);
    assign div_rem    = (alu_op == 4'd13) || (alu_op == 4'd14);
    assign a_neg      = div_signed & op_a[31];
    assign b_neg      = div_signed & op_b[31];
    assign a_mag      = a_neg ? (~op_a + 32'd1) : op_a;
    assign b_mag      = b_neg ? (~op_b + 32'd1) : op_b;

    // Restoring step: dividend bits shift out of quo_q into the partial remainder.
    assign rem_sh = {rem_q, quo_q[31]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign ge     = ~diff[32];
    assign rem_nx = ge ? diff[31:0] : rem_sh[31:0];
    assign quo_nx = {quo_q[30:0], ge};

    // Divide-by-zero quotient is all ones regardless of the dividend sign.
    assign q_fin   = dz_q ? 32'hFFFF_FFFF : (qneg_q ? (~quo_nx + 32'd1) : quo_nx);
    assign r_fin   = rneg_q ? (~rem_nx + 32'd1) : rem_nx;
    assign div_res = remop_q ? r_fin : q_fin;
    assign result  = (state_q == StRun) ? div_res : alu_out;

    assign ex_busy = ((state_q == StIdle) & valid_ex & is_div & ~flush) |
                     ((state_q == StRun) & (cnt_q != 6'd1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dz_d    = dz_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        remop_d = remop_q;
        unique case (state_q)
            StIdle: begin
                if (valid_ex && !flush && is_div) begin
                    state_d = StRun;
                    cnt_d   = 6'd32;
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    dz_d    = (op_b == 32'd0);
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    remop_d = div_rem;
                end
            end
            StRun: begin
                if (flush || (cnt_q == 6'd1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dz_q    <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            remop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dz_q    <= dz_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            remop_q <= remop_d;
        end
    end

    always_comb begin
        cond = 1'b0;
        unique case (funct3)
            3'b000:  cond = (rs1_data == rs2_data);
            3'b001:  cond = (rs1_data != rs2_data);
            3'b100:  cond = ($signed(rs1_data) < $signed(rs2_data));
            3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  cond = (rs1_data < rs2_data);
            3'b111:  cond = (rs1_data >= rs2_data);
            default: cond = 1'b0;
        endcase
    end

    assign taken  = jal | jalr | (branch_en & cond);
    assign target = jalr ? ((rs1_data + imm) & ~32'd1) : (pc_ex + imm);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ctrl_mem      <= '0;
            rd_mem        <= '0;
            pc4_mem       <= '0;
            alu_result    <= '0;
            write_data    <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else if (!valid_ex || ex_busy) begin
            ctrl_mem     <= '0;
            branch_taken <= 1'b0;
        end else begin
            ctrl_mem      <= ctrl_ex;
            rd_mem        <= rd_ex;
            pc4_mem       <= pc4_ex;
            alu_result    <= result;
            write_data    <= rs2_data;
            branch_taken  <= taken;
            branch_target <= target;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, branches, divider latency
// and corner cases, and flush of an in-flight divide.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset, valid_ex, flush, alu_src, branch_en, jal, jalr;
    logic [4:0]  ctrl_ex;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data, imm, pc_ex, pc4_ex, rd_ex;
    logic [4:0]  ctrl_mem;
    logic [31:0] rd_mem, pc4_mem, alu_result, write_data, branch_target;
    logic        branch_taken, ex_busy;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    ex_stage u_dut (
        .clk          (clk),
        .reset        (reset),
        .valid_ex     (valid_ex),
        .flush        (flush),
        .ctrl_ex      (ctrl_ex),
        .alu_op       (alu_op),
        .alu_src      (alu_src),
        .branch_en    (branch_en),
        .funct3       (funct3),
        .jal          (jal),
        .jalr         (jalr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .imm          (imm),
        .pc_ex        (pc_ex),
        .pc4_ex       (pc4_ex),
        .rd_ex        (rd_ex),
        .ctrl_mem     (ctrl_mem),
        .rd_mem       (rd_mem),
        .pc4_mem      (pc4_mem),
        .alu_result   (alu_result),
        .write_data   (write_data),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .ex_busy      (ex_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] im, input logic src);
        valid_ex  = 1'b1;
        alu_op    = op;
        rs1_data  = a;
        rs2_data  = b;
        imm       = im;
        alu_src   = src;
        branch_en = 1'b0;
        jal       = 1'b0;
        jalr      = 1'b0;
        ctrl_ex   = 5'h05;
    endtask

    task automatic run_div(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int  busy_n;
        int  cyc;
        logic done;
        set_alu(op, a, b, 32'h0, 1'b0);
        ctrl_ex = 5'h13;
        busy_n  = 0;
        cyc     = 0;
        done    = 1'b0;
        while (!done && cyc < 40) begin
            #1;
            if (ex_busy) busy_n++;
            @(posedge clk);
            #1;
            cyc++;
            if (ctrl_mem != 5'h0) done = 1'b1;
        end
        check({tag, " latency"}, 32'(cyc), 32'd33);
        check({tag, " busy cycles"}, 32'(busy_n), 32'd32);
        check({tag, " result"}, alu_result, exp);
        check({tag, " ctrl"}, 32'(ctrl_mem), 32'h13);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        funct3 = 3'b000;
        pc_ex  = 32'h100;
        pc4_ex = 32'h104;
        rd_ex  = 32'd5;
        set_alu(4'd0, 32'd9, 32'd9, 32'd0, 1'b0);

        // Reset held 3 cycles with ADD traffic present.
        repeat (3) tick();
        check("rst ctrl_mem", 32'(ctrl_mem), 32'h0);
        check("rst alu_result", alu_result, 32'h0);
        check("rst rd_mem", rd_mem, 32'h0);
        check("rst pc4_mem", pc4_mem, 32'h0);
        check("rst write_data", write_data, 32'h0);
        check("rst branch_taken", 32'(branch_taken), 32'h0);
        check("rst branch_target", branch_target, 32'h0);
        check("rst ex_busy", 32'(ex_busy), 32'h0);

        reset = 1'b0;
        set_alu(4'd0, 32'd5, 32'd7, 32'd0, 1'b0);
        tick();
        check("add 5+7", alu_result, 32'd12);
        check("add ctrl", 32'(ctrl_mem), 32'h05);
        check("add rd", rd_mem, 32'd5);
        check("add pc4", pc4_mem, 32'h104);
        check("add wdata", write_data, 32'd7);

        set_alu(4'd7, 32'h8000_0000, 32'd0, 32'd4, 1'b1);
        tick();
        check("sra", alu_result, 32'hF800_0000);
        set_alu(4'd4, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        tick();
        check("sltu", alu_result, 32'd1);
        set_alu(4'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        tick();
        check("slt", alu_result, 32'd1);
        set_alu(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        tick();
        check("add wrap", alu_result, 32'd0);
        set_alu(4'd10, 32'd3, 32'd0, 32'h1234_5000, 1'b1);
        tick();
        check("passb", alu_result, 32'h1234_5000);

        // Divides issued back-to-back with no idle cycle between them.
        run_div("div -7/2", 4'd11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_div("rem -7%2", 4'd13, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_div("divu 5/0", 4'd12, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_div("remu 5%0", 4'd14, 32'd5, 32'd0, 32'd5);
        run_div("div ovf", 4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div("rem ovf", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_div("divu 100/7", 4'd12, 32'd100, 32'd7, 32'd14);

        // Branches and jumps.
        set_alu(4'd0, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0);
        branch_en = 1'b1;
        funct3    = 3'b100;
        pc_ex     = 32'h2000;
        tick();
        check("blt taken", 32'(branch_taken), 32'd1);
        check("blt target", branch_target, 32'h2040);
        valid_ex  = 1'b0;
        branch_en = 1'b0;
        tick();
        check("taken pulse", 32'(branch_taken), 32'd0);
        check("bubble ctrl", 32'(ctrl_mem), 32'h0);

        set_alu(4'd0, 32'h1001, 32'd0, 32'd2, 1'b1);
        jalr = 1'b1;
        tick();
        check("jalr taken", 32'(branch_taken), 32'd1);
        check("jalr target", branch_target, 32'h1002);

        set_alu(4'd0, 32'd1, 32'hFFFF_FFFF, 32'h8, 1'b0);
        branch_en = 1'b1;
        funct3    = 3'b111;
        tick();
        check("bgeu not taken", 32'(branch_taken), 32'd0);
        check("bgeu ctrl", 32'(ctrl_mem), 32'h05);

        // Flush and divide in the same cycle: flush wins.
        set_alu(4'd11, 32'd100, 32'd3, 32'd0, 1'b0);
        flush = 1'b1;
        #1;
        check("flush+div busy", 32'(ex_busy), 32'd0);
        tick();
        check("flush+div ctrl", 32'(ctrl_mem), 32'h0);
        flush    = 1'b0;
        valid_ex = 1'b0;
        #1;
        check("flush+div no start", 32'(ex_busy), 32'd0);
        tick();

        // DIV in flight, flushed at t+10; ADD issued at t+11 completes.
        set_alu(4'd11, 32'd100, 32'd3, 32'd0, 1'b0);
        #1;
        check("div issue busy", 32'(ex_busy), 32'd1);
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flushed ctrl", 32'(ctrl_mem), 32'h0);
        check("flushed result", alu_result, 32'h0);
        set_alu(4'd0, 32'd2, 32'd3, 32'd0, 1'b0);
        #1;
        check("post-flush busy", 32'(ex_busy), 32'd0);
        tick();
        check("post-flush add", alu_result, 32'd5);
        check("post-flush ctrl", 32'(ctrl_mem), 32'h05);
        valid_ex = 1'b0;
        repeat (2) tick();
        check("idle busy", 32'(ex_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
